// File: rtl/zmodem_rx_pkg.sv
// Shared state encoding, error codes and framing constants for the receive frame sequencer.
package zmodem_rx_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int SYMS_PER_BLK = 64;
    localparam int SYM_CNT_W    = $clog2(SYMS_PER_BLK);
    localparam int HDR_SYMS     = 8;
    localparam int SYNC_SYMS    = 16;

    // Number of differing bits between two 32-bit words.
    function automatic logic [5:0] hamming32(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] diff;
        logic [5:0]  cnt;
        diff = a ^ b;
        cnt  = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, diff[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sync_correlator.sv
// Sliding 16-symbol sync detector; the match pulse follows the completing symbol by one cycle.
module sync_correlator
    import zmodem_rx_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD = 32'hD391_7A2C,
    parameter int unsigned SYNC_TOL  = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] symbol_in,
    input  logic       symbol_valid,
    output logic       match
);

    logic [29:0] hist_r;
    logic [4:0]  fill_r;
    logic        match_r;
    logic [31:0] hist_next_s;
    logic        hit_s;

    // Candidate window including this cycle's symbol, compared against the sync word.
    always_comb begin
        hist_next_s = {hist_r, symbol_in};
        hit_s       = 1'b0;
        if (enable && symbol_valid && (fill_r >= 5'(SYNC_SYMS - 1)) &&
            (hamming32(hist_next_s, SYNC_WORD) <= 6'(SYNC_TOL))) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // History shift register; disabling wipes it so the zeroed window can never match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_r  <= 30'd0;
            fill_r  <= 5'd0;
            match_r <= 1'b0;
        end else if (!enable) begin
            hist_r  <= 30'd0;
            fill_r  <= 5'd0;
            match_r <= 1'b0;
        end else begin
            match_r <= hit_s;
            if (symbol_valid) begin
                hist_r <= hist_next_s[29:0];
                if (fill_r != 5'(SYNC_SYMS)) begin
                    fill_r <= fill_r + 5'd1;
                end
            end
        end
    end

    assign match = match_r;

endmodule

// File: rtl/rx_frame_sequencer.sv
// Receive-side frame controller: sync hunt, block-count header, gated payload forwarding,
// decryptor handshake supervision and abort/flush handling.
module rx_frame_sequencer
    import zmodem_rx_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD   = 32'hD391_7A2C,
    parameter int unsigned SYNC_TOL    = 0,
    parameter int unsigned MAX_BLOCKS  = 1024,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  symbol_in,
    input  logic        symbol_valid,
    output logic [1:0]  des_symbol_in,
    output logic        des_symbol_valid,
    output logic        des_flush,
    input  logic        des_block_valid,
    input  logic        dec_ready,
    output logic        frame_active,
    output logic [15:0] frame_len,
    output logic [15:0] blocks_done,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC);

    state_t                state_r;
    logic [2:0]            hdr_cnt_r;
    logic [13:0]           hdr_shift_r;
    logic [SYM_CNT_W-1:0]  sym_cnt_r;
    logic [15:0]           blk_idx_r;
    logic                  blk_pending_r;
    logic [IDLE_W-1:0]     idle_cnt_r;

    logic [1:0]            des_symbol_in_r;
    logic                  des_symbol_valid_r;
    logic                  des_flush_r;
    logic                  frame_active_r;
    logic [15:0]           frame_len_r;
    logic [15:0]           blocks_done_r;
    logic                  frame_done_r;
    logic                  frame_err_r;
    logic [1:0]            err_code_r;

    logic                  match_s;
    logic                  hunt_en_s;
    logic                  hs_s;
    logic [15:0]           len_s;
    logic                  len_bad_s;
    logic                  hdr_last_s;
    logic                  blk_last_s;
    logic                  idle_hit_s;
    logic                  abort_s;
    logic [1:0]            abort_code_s;

    // The correlator stays enabled only while hunting and not already reporting a lock.
    assign hunt_en_s = (state_r == HUNT) && !match_s;

    sync_correlator #(
        .SYNC_WORD (SYNC_WORD),
        .SYNC_TOL  (SYNC_TOL)
    ) u_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (hunt_en_s),
        .symbol_in    (symbol_in),
        .symbol_valid (symbol_valid),
        .match        (match_s)
    );

    assign hs_s       = des_block_valid && dec_ready && blk_pending_r;
    assign len_s      = {hdr_shift_r, symbol_in};
    assign len_bad_s  = (len_s == 16'd0) || (len_s > 16'(MAX_BLOCKS));
    assign hdr_last_s = (hdr_cnt_r == 3'(HDR_SYMS - 1));
    assign blk_last_s = (sym_cnt_r == SYM_CNT_W'(SYMS_PER_BLK - 1));
    assign idle_hit_s = (idle_cnt_r == IDLE_W'(TIMEOUT_CYC - 1));

    // Abort decision for this cycle; activity in the same cycle always beats the timeout.
    always_comb begin
        abort_s      = 1'b0;
        abort_code_s = ERR_NONE;
        case (state_r)
            HEADER: begin
                if (symbol_valid) begin
                    if (hdr_last_s && len_bad_s) begin
                        abort_s      = 1'b1;
                        abort_code_s = ERR_LEN;
                    end else begin
                        abort_s      = 1'b0;
                        abort_code_s = ERR_NONE;
                    end
                end else if (idle_hit_s) begin
                    abort_s      = 1'b1;
                    abort_code_s = ERR_TIMEOUT;
                end else begin
                    abort_s      = 1'b0;
                    abort_code_s = ERR_NONE;
                end
            end
            PAYLOAD: begin
                if (symbol_valid) begin
                    if (blk_pending_r && !hs_s) begin
                        abort_s      = 1'b1;
                        abort_code_s = ERR_OVERRUN;
                    end else begin
                        abort_s      = 1'b0;
                        abort_code_s = ERR_NONE;
                    end
                end else if (idle_hit_s) begin
                    abort_s      = 1'b1;
                    abort_code_s = ERR_TIMEOUT;
                end else begin
                    abort_s      = 1'b0;
                    abort_code_s = ERR_NONE;
                end
            end
            DRAIN: begin
                if (!hs_s && idle_hit_s) begin
                    abort_s      = 1'b1;
                    abort_code_s = ERR_TIMEOUT;
                end else begin
                    abort_s      = 1'b0;
                    abort_code_s = ERR_NONE;
                end
            end
            default: begin
                abort_s      = 1'b0;
                abort_code_s = ERR_NONE;
            end
        endcase
    end

    // Frame state machine with all outputs registered; abort handling overrides the state branches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r            <= HUNT;
            hdr_cnt_r          <= 3'd0;
            hdr_shift_r        <= 14'd0;
            sym_cnt_r          <= '0;
            blk_idx_r          <= 16'd0;
            blk_pending_r      <= 1'b0;
            idle_cnt_r         <= '0;
            des_symbol_in_r    <= 2'd0;
            des_symbol_valid_r <= 1'b0;
            des_flush_r        <= 1'b0;
            frame_active_r     <= 1'b0;
            frame_len_r        <= 16'd0;
            blocks_done_r      <= 16'd0;
            frame_done_r       <= 1'b0;
            frame_err_r        <= 1'b0;
            err_code_r         <= ERR_NONE;
        end else begin
            des_symbol_valid_r <= 1'b0;
            des_flush_r        <= 1'b0;
            frame_done_r       <= 1'b0;
            frame_err_r        <= 1'b0;

            if (hs_s) begin
                blk_pending_r <= 1'b0;
                blocks_done_r <= blocks_done_r + 16'd1;
            end

            case (state_r)
                HUNT: begin
                    idle_cnt_r <= '0;
                    if (match_s) begin
                        state_r        <= HEADER;
                        frame_active_r <= 1'b1;
                        err_code_r     <= ERR_NONE;
                        blocks_done_r  <= 16'd0;
                        // A symbol arriving alongside the match pulse is already header symbol 0.
                        hdr_shift_r    <= {12'd0, symbol_in};
                        hdr_cnt_r      <= symbol_valid ? 3'd1 : 3'd0;
                    end
                end
                HEADER: begin
                    if (symbol_valid) begin
                        idle_cnt_r  <= '0;
                        hdr_shift_r <= len_s[13:0];
                        hdr_cnt_r   <= hdr_cnt_r + 3'd1;
                        if (hdr_last_s) begin
                            frame_len_r <= len_s;
                            state_r     <= PAYLOAD;
                            sym_cnt_r   <= '0;
                            blk_idx_r   <= 16'd0;
                        end
                    end else begin
                        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                    end
                end
                PAYLOAD: begin
                    if (symbol_valid) begin
                        idle_cnt_r         <= '0;
                        des_symbol_in_r    <= symbol_in;
                        des_symbol_valid_r <= 1'b1;
                        if (blk_last_s) begin
                            sym_cnt_r     <= '0;
                            blk_pending_r <= 1'b1;
                            if (blk_idx_r == (frame_len_r - 16'd1)) begin
                                state_r <= DRAIN;
                            end else begin
                                blk_idx_r <= blk_idx_r + 16'd1;
                            end
                        end else begin
                            sym_cnt_r <= sym_cnt_r + SYM_CNT_W'(1);
                        end
                    end else begin
                        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                    end
                end
                DRAIN: begin
                    if (hs_s) begin
                        idle_cnt_r     <= '0;
                        frame_done_r   <= 1'b1;
                        frame_active_r <= 1'b0;
                        state_r        <= HUNT;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                    end
                end
                default: begin
                    state_r <= HUNT;
                end
            endcase

            if (abort_s) begin
                state_r            <= HUNT;
                frame_err_r        <= 1'b1;
                err_code_r         <= abort_code_s;
                des_flush_r        <= 1'b1;
                frame_active_r     <= 1'b0;
                blk_pending_r      <= 1'b0;
                des_symbol_valid_r <= 1'b0;
                idle_cnt_r         <= '0;
            end
        end
    end

    assign des_symbol_in    = des_symbol_in_r;
    assign des_symbol_valid = des_symbol_valid_r;
    assign des_flush        = des_flush_r;
    assign frame_active     = frame_active_r;
    assign frame_len        = frame_len_r;
    assign blocks_done      = blocks_done_r;
    assign frame_done       = frame_done_r;
    assign frame_err        = frame_err_r;
    assign err_code         = err_code_r;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed bench for rx_frame_sequencer: a strict-sync instance and a one-bit-tolerant instance
// share the same stimulus.
module tb_rx_frame_sequencer;
    import zmodem_rx_pkg::*;

    localparam logic [31:0] SYNC = 32'hD391_7A2C;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  symbol_in;
    logic        symbol_valid;
    logic        des_block_valid;
    logic        dec_ready;

    logic [1:0]  des_symbol_in_a,  des_symbol_in_b;
    logic        des_symbol_valid_a, des_symbol_valid_b;
    logic        des_flush_a, des_flush_b;
    logic        frame_active_a, frame_active_b;
    logic [15:0] frame_len_a, frame_len_b;
    logic [15:0] blocks_done_a, blocks_done_b;
    logic        frame_done_a, frame_done_b;
    logic        frame_err_a, frame_err_b;
    logic [1:0]  err_code_a, err_code_b;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int dones = 0;
    int errs = 0;
    int flushes = 0;

    typedef struct {
        logic [15:0] hdr;
        logic [1:0]  exp_err;
        logic [15:0] exp_len;
    } hdr_vec_t;

    hdr_vec_t hdr_tab [5];

    always #5 clk = ~clk;

    rx_frame_sequencer #(.SYNC_TOL(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .symbol_in(symbol_in), .symbol_valid(symbol_valid),
        .des_symbol_in(des_symbol_in_a), .des_symbol_valid(des_symbol_valid_a),
        .des_flush(des_flush_a), .des_block_valid(des_block_valid), .dec_ready(dec_ready),
        .frame_active(frame_active_a), .frame_len(frame_len_a), .blocks_done(blocks_done_a),
        .frame_done(frame_done_a), .frame_err(frame_err_a), .err_code(err_code_a)
    );

    rx_frame_sequencer #(.SYNC_TOL(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .symbol_in(symbol_in), .symbol_valid(symbol_valid),
        .des_symbol_in(des_symbol_in_b), .des_symbol_valid(des_symbol_valid_b),
        .des_flush(des_flush_b), .des_block_valid(des_block_valid), .dec_ready(dec_ready),
        .frame_active(frame_active_b), .frame_len(frame_len_b), .blocks_done(blocks_done_b),
        .frame_done(frame_done_b), .frame_err(frame_err_b), .err_code(err_code_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [1:0] s, input logic bv, input logic rdy);
        symbol_valid    = v;
        symbol_in       = s;
        des_block_valid = bv;
        dec_ready       = rdy;
        @(posedge clk);
        #1;
        if (des_symbol_valid_a) strobes++;
        if (frame_done_a) dones++;
        if (frame_err_a) errs++;
        if (des_flush_a) flushes++;
    endtask

    function automatic logic [1:0] sym_of(input int i);
        logic [31:0] v;
        v = i;
        return v[1:0] ^ v[3:2];
    endfunction

    task automatic send_sync(input logic [31:0] word);
        logic [31:0] w;
        w = word;
        for (int i = 0; i < 16; i++) step(1'b1, w[31-2*i -: 2], 1'b0, 1'b1);
    endtask

    task automatic send_header(input logic [15:0] hdr);
        logic [15:0] h;
        h = hdr;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, h[15-2*i -: 2], 1'b0, 1'b1);
            if (i == 0) begin
                check("lock_active", frame_active_a, 1);
                check("lock_err_clear", err_code_a, ERR_NONE);
                check("lock_blocks_clear", blocks_done_a, 0);
            end
        end
    endtask

    // Payload with one idle slot after each symbol; block ends get a handshake, optionally delayed.
    task automatic run_payload(input int nblk, input int stall);
        logic [1:0] s;
        for (int i = 0; i < nblk * 64; i++) begin
            s = sym_of(i);
            step(1'b1, s, 1'b0, 1'b1);
            check("fwd_valid", des_symbol_valid_a, 1);
            check("fwd_data", des_symbol_in_a, s);
            if ((i % 64) == 63) begin
                for (int k = 0; k < stall; k++) step(1'b0, 2'd0, 1'b1, 1'b0);
                step(1'b0, 2'd0, 1'b1, 1'b1);
            end else begin
                step(1'b0, 2'd0, 1'b0, 1'b1);
            end
            check("fwd_gap", des_symbol_valid_a, 0);
        end
    endtask

    initial begin
        int s0, d0, e0, f0;

        hdr_tab[0] = '{hdr: 16'h0000, exp_err: ERR_LEN, exp_len: 16'h0000};
        hdr_tab[1] = '{hdr: 16'h0401, exp_err: ERR_LEN, exp_len: 16'h0401};
        hdr_tab[2] = '{hdr: 16'hFFFF, exp_err: ERR_LEN, exp_len: 16'hFFFF};
        hdr_tab[3] = '{hdr: 16'h8000, exp_err: ERR_LEN, exp_len: 16'h8000};
        hdr_tab[4] = '{hdr: 16'h0800, exp_err: ERR_LEN, exp_len: 16'h0800};

        reset_n = 1'b0;
        symbol_in = 2'd0;
        symbol_valid = 1'b0;
        des_block_valid = 1'b0;
        dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {des_symbol_in_a, des_symbol_valid_a, des_flush_a, frame_active_a, frame_len_a,
               blocks_done_a, frame_done_a, frame_err_a, err_code_a}, 64'd0);
        reset_n = 1'b1;
        repeat (20) step(1'b0, 2'd0, 1'b0, 1'b1);
        check("idle_no_lock", frame_active_a, 0);

        // T1: two-block frame, decryptor always ready.
        s0 = strobes; d0 = dones;
        send_sync(SYNC);
        send_header(16'h0002);
        check("t1_len", frame_len_a, 16'h0002);
        run_payload(2, 0);
        check("t1_done_pulse", frame_done_a, 1);
        check("t1_blocks", blocks_done_a, 2);
        check("t1_active_low", frame_active_a, 0);
        check("t1_err", err_code_a, ERR_NONE);
        check("t1_strobes", strobes - s0, 128);
        check("t1_done_count", dones - d0, 1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("t1_done_once", frame_done_a, 0);

        // T2: handshake delayed 20 cycles after each block end.
        e0 = errs;
        send_sync(SYNC);
        send_header(16'h0002);
        run_payload(2, 20);
        check("t2_done_pulse", frame_done_a, 1);
        check("t2_blocks", blocks_done_a, 2);
        check("t2_no_err", errs - e0, 0);
        check("t2_err", err_code_a, ERR_NONE);

        // T3: 65th payload symbol while block 0 is still unaccepted.
        s0 = strobes; f0 = flushes;
        send_sync(SYNC);
        send_header(16'h0002);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, sym_of(i), 1'b0, 1'b0);
            step(1'b0, 2'd0, 1'b0, 1'b0);
        end
        step(1'b0, 2'd0, 1'b1, 1'b0);
        step(1'b1, 2'b11, 1'b1, 1'b0);
        check("t3_err_pulse", frame_err_a, 1);
        check("t3_err_code", err_code_a, ERR_OVERRUN);
        check("t3_flush", des_flush_a, 1);
        check("t3_not_fwd", des_symbol_valid_a, 0);
        check("t3_active_low", frame_active_a, 0);
        check("t3_blocks", blocks_done_a, 0);
        check("t3_strobes", strobes - s0, 64);
        step(1'b1, 2'b01, 1'b1, 1'b0);
        check("t3_pulse_end", {frame_err_a, des_flush_a, des_symbol_valid_a}, 0);
        check("t3_err_held", err_code_a, ERR_OVERRUN);
        check("t3_flush_count", flushes - f0, 1);

        // T4: illegal header lengths from the table, then a legal one-block frame.
        for (int t = 0; t < 5; t++) begin
            send_sync(SYNC);
            send_header(hdr_tab[t].hdr);
            check("t4_err_pulse", frame_err_a, 1);
            check("t4_err_code", err_code_a, hdr_tab[t].exp_err);
            check("t4_len", frame_len_a, hdr_tab[t].exp_len);
            check("t4_flush", des_flush_a, 1);
            check("t4_active_low", frame_active_a, 0);
            repeat (3) step(1'b0, 2'd0, 1'b0, 1'b1);
            check("t4_err_held", err_code_a, hdr_tab[t].exp_err);
        end
        send_sync(SYNC);
        send_header(16'h0001);
        run_payload(1, 0);
        check("t4_valid_done", frame_done_a, 1);
        check("t4_valid_err", err_code_a, ERR_NONE);
        check("t4_valid_blocks", blocks_done_a, 1);

        // T5: payload stall one short of the timeout, then exactly the timeout.
        e0 = errs;
        send_sync(SYNC);
        send_header(16'h0001);
        for (int i = 0; i < 10; i++) step(1'b1, sym_of(i), 1'b0, 1'b1);
        repeat (4095) step(1'b0, 2'd0, 1'b0, 1'b1);
        check("t5_short_stall", errs - e0, 0);
        check("t5_still_active", frame_active_a, 1);
        step(1'b1, 2'b10, 1'b0, 1'b1);
        check("t5_resume_fwd", des_symbol_valid_a, 1);
        for (int i = 0; i < 4096; i++) begin
            step(1'b0, 2'd0, 1'b0, 1'b1);
            if (i == 4094) check("t5_before_limit", frame_err_a, 0);
            if (i == 4095) begin
                check("t5_timeout_pulse", frame_err_a, 1);
                check("t5_timeout_code", err_code_a, ERR_TIMEOUT);
                check("t5_timeout_flush", des_flush_a, 1);
                check("t5_active_low", frame_active_a, 0);
            end
        end

        // T6: tolerant instance locks on 1 flipped bit, not on 2; reset mid-payload.
        repeat (4) step(1'b0, 2'd0, 1'b0, 1'b1);
        send_sync(SYNC ^ 32'h0000_0101);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("t6_two_flip_b", frame_active_b, 0);
        check("t6_two_flip_a", frame_active_a, 0);
        send_sync(SYNC ^ 32'h0000_0100);
        step(1'b1, 2'b00, 1'b0, 1'b1);
        check("t6_one_flip_b", frame_active_b, 1);
        check("t6_one_flip_a", frame_active_a, 0);
        for (int i = 1; i < 8; i++) step(1'b1, (i == 7) ? 2'b10 : 2'b00, 1'b0, 1'b1);
        check("t6_len_b", frame_len_b, 16'h0002);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, sym_of(i), 1'b0, 1'b1);
            step(1'b0, 2'd0, (i == 63) ? 1'b1 : 1'b0, 1'b1);
        end
        check("t6_blocks_b", blocks_done_b, 1);
        repeat (3) step(1'b1, 2'b11, 1'b0, 1'b1);
        check("t6_fwd_b", {des_symbol_valid_b, des_symbol_in_b}, {1'b1, 2'b11});
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_reset_b",
              {des_symbol_in_b, des_symbol_valid_b, des_flush_b, frame_active_b, frame_len_b,
               blocks_done_b, frame_done_b, frame_err_b, err_code_b}, 64'd0);
        check("t6_reset_a",
              {des_symbol_in_a, des_symbol_valid_a, des_flush_a, frame_active_a, frame_len_a,
               blocks_done_a, frame_done_a, frame_err_a, err_code_a}, 64'd0);
        #2;
        reset_n = 1'b1;
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("t6_post_reset_b", {frame_active_b, frame_err_b, frame_done_b, des_flush_b}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
